// File: rtl/cpu6_fetch_buffer_pkg.sv
// Shared constants for the cpu6 instruction fetch buffer.
package cpu6_fetch_buffer_pkg;

  localparam int unsigned Cpu6Xlen          = 32;
  localparam logic [31:0] Cpu6ResetPc       = 32'h0000_0000;
  localparam int unsigned Cpu6FetchbufDepth = 4;
  localparam int unsigned Cpu6IdxW          = 8;

  // Occupancy needs one extra bit so that full and empty are distinguishable.
  function automatic int unsigned cnt_width(int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/cpu6_fetch_buffer_if.sv
// Fetch buffer bus: icache address/data, core redirect and the decode-side handshake.
interface cpu6_fetch_buffer_if
  import cpu6_fetch_buffer_pkg::*;
#(
  parameter int unsigned XLEN  = Cpu6Xlen,
  parameter int unsigned DEPTH = Cpu6FetchbufDepth,
  parameter int unsigned IDX_W = Cpu6IdxW
);
  localparam int unsigned CntW = cnt_width(DEPTH);

  logic [IDX_W-1:0] icache_addr;
  logic [XLEN-1:0]  icache_instr;
  logic             redirect_valid;
  logic [XLEN-1:0]  redirect_pc;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_pc;
  logic [XLEN-1:0]  out_instr;
  logic [CntW-1:0]  count;

  modport master (
    output icache_addr,
    input  icache_instr,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_pc,
    output out_instr,
    output count
  );

  modport slave (
    input  icache_addr,
    output icache_instr,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_pc,
    input  out_instr,
    input  count
  );

endinterface

// File: rtl/cpu6_fetch_buffer_fifo.sv
// Generic synchronous FIFO with flush; head data comes straight from the storage registers.
module cpu6_fetch_buffer_fifo #(
  parameter  int unsigned Width = 64,
  parameter  int unsigned Depth = 4,
  localparam int unsigned PtrW  = $clog2(Depth),
  localparam int unsigned CntW  = PtrW + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic [CntW-1:0]  count_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (push_i && !pop_i) begin
      count_d = count_q + CntW'(1);
    end else if (!push_i && pop_i) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush_i) begin
      // Flush beats any concurrent push or pop.
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (pop_i) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      count_q <= count_d;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/cpu6_fetch_buffer.sv
// Instruction prefetch: walks fetch_pc through the combinational icache into a FIFO,
// restarting at the target on a core redirect.
module cpu6_fetch_buffer
  import cpu6_fetch_buffer_pkg::*;
#(
  parameter int unsigned     XLEN     = Cpu6Xlen,
  parameter int unsigned     DEPTH    = Cpu6FetchbufDepth,
  parameter int unsigned     IDX_W    = Cpu6IdxW,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(Cpu6ResetPc)
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  cpu6_fetch_buffer_if.master fb_io
);

  localparam int unsigned CntW = cnt_width(DEPTH);

  logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
  logic              push, pop;
  logic [CntW-1:0]   count;
  logic [2*XLEN-1:0] head;
  logic              unused_rpc_low;

  assign unused_rpc_low = ^fb_io.redirect_pc[1:0];

  assign pop  = fb_io.out_valid & fb_io.out_ready;
  // A pop frees a slot in the same cycle, so a full buffer still streams 1/cycle.
  assign push = !fb_io.redirect_valid && ((count < CntW'(DEPTH)) || pop);

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (fb_io.redirect_valid) begin
      fetch_pc_d = {fb_io.redirect_pc[XLEN-1:2], 2'b00};
    end else if (push) begin
      fetch_pc_d = fetch_pc_q + XLEN'(4);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_pc_q <= RESET_PC;
    end else begin
      fetch_pc_q <= fetch_pc_d;
    end
  end

  cpu6_fetch_buffer_fifo #(
    .Width (2 * XLEN),
    .Depth (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (fb_io.redirect_valid),
    .push_i  (push),
    .wdata_i ({fetch_pc_q, fb_io.icache_instr}),
    .pop_i   (pop),
    .rdata_o (head),
    .count_o (count)
  );

  assign fb_io.icache_addr = fetch_pc_q[IDX_W+1:2];
  assign fb_io.out_valid   = (count != '0);
  assign fb_io.out_pc      = head[2*XLEN-1:XLEN];
  assign fb_io.out_instr   = head[XLEN-1:0];
  assign fb_io.count       = count;

endmodule

// File: tb/tb_cpu6_fetch_buffer.sv
// Self-checking bench for cpu6_fetch_buffer against a queue-based fetch model.
module tb_cpu6_fetch_buffer;
  import cpu6_fetch_buffer_pkg::*;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned IDX_W = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  cpu6_fetch_buffer_if #(.XLEN(XLEN), .DEPTH(DEPTH), .IDX_W(IDX_W)) fb ();

  cpu6_fetch_buffer #(
    .XLEN     (XLEN),
    .DEPTH    (DEPTH),
    .IDX_W    (IDX_W),
    .RESET_PC (32'h0)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .fb_io  (fb.master)
  );

  logic [31:0] mem [256];
  assign fb.icache_instr = mem[fb.icache_addr];

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: an ordered list of fetched {pc, instr} and the next PC to fetch.
  logic [63:0] mq[$];
  logic [31:0] mpc;

  task automatic model_reset();
    mq.delete();
    mpc = 32'h0;
  endtask

  task automatic cycle(input logic rv, input logic [31:0] rpc, input logic rdy);
    bit pop, push;
    fb.redirect_valid = rv;
    fb.redirect_pc    = rpc;
    fb.out_ready      = rdy;
    @(posedge clk);
    if (rv) begin
      mq.delete();
      mpc = {rpc[31:2], 2'b00};
    end else begin
      pop  = rdy && (mq.size() != 0);
      push = (mq.size() < DEPTH) || pop;
      if (pop) void'(mq.pop_front());
      if (push) begin
        mq.push_back({mpc, mem[mpc[9:2]]});
        mpc = mpc + 32'd4;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    fb.redirect_valid = 1'b0;
    fb.redirect_pc    = '0;
    fb.out_ready      = 1'b0;
    rst_n = 1'b0;
    #2;
    tests_run++;
    if (fb.out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL reset_valid: got %0b want 0", fb.out_valid);
    end
    tests_run++;
    if (fb.count !== 3'd0) begin
      tests_failed++; $display("FAIL reset_count: got %0d want 0", fb.count);
    end
    tests_run++;
    if (fb.out_pc !== 32'h0 || fb.out_instr !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_head: got pc %h instr %h want 0 0", fb.out_pc, fb.out_instr);
    end
    tests_run++;
    if (fb.icache_addr !== 8'h0) begin
      tests_failed++; $display("FAIL reset_addr: got %h want 00", fb.icache_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_stream();
    cycle(1'b0, '0, 1'b1);
    tests_run++;
    if (fb.out_valid !== 1'b1 || fb.out_pc !== 32'h0 || fb.out_instr !== 32'h1000) begin
      tests_failed++;
      $display("FAIL stream_first: got v%0b pc %h instr %h want v1 pc 0 instr 1000",
               fb.out_valid, fb.out_pc, fb.out_instr);
    end
    for (int k = 1; k < 8; k++) begin
      cycle(1'b0, '0, 1'b1);
      tests_run++;
      if (fb.out_valid !== 1'b1 || fb.out_pc !== 32'(4 * k) || fb.out_instr !== 32'(32'h1000 + k)
          || fb.count !== 3'd1) begin
        tests_failed++;
        $display("FAIL stream_%0d: got v%0b pc %h instr %h cnt %0d want v1 pc %h instr %h cnt 1",
                 k, fb.out_valid, fb.out_pc, fb.out_instr, fb.count, 4 * k, 32'h1000 + k);
      end
    end
  endtask

  task automatic test_stall();
    cycle(1'b1, 32'h0, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b0);
    tests_run++;
    if (fb.count !== 3'd4) begin
      tests_failed++; $display("FAIL stall_count: got %0d want 4", fb.count);
    end
    tests_run++;
    if (fb.icache_addr !== 8'h04) begin
      tests_failed++; $display("FAIL stall_addr: got %h want 04", fb.icache_addr);
    end
    for (int k = 0; k < 6; k++) begin
      tests_run++;
      if (fb.out_pc !== 32'(4 * k) || fb.out_instr !== 32'(32'h1000 + k) || fb.count !== 3'd4) begin
        tests_failed++;
        $display("FAIL stall_drain_%0d: got pc %h instr %h cnt %0d want pc %h instr %h cnt 4",
                 k, fb.out_pc, fb.out_instr, fb.count, 4 * k, 32'h1000 + k);
      end
      cycle(1'b0, '0, 1'b1);
    end
  endtask

  task automatic test_redirect_full();
    cycle(1'b0, '0, 1'b0);
    cycle(1'b1, 32'h40, 1'b1);
    tests_run++;
    if (fb.out_valid !== 1'b0 || fb.count !== 3'd0 || fb.icache_addr !== 8'h10) begin
      tests_failed++;
      $display("FAIL redir_full_flush: got v%0b cnt %0d addr %h want v0 cnt 0 addr 10",
               fb.out_valid, fb.count, fb.icache_addr);
    end
    cycle(1'b0, '0, 1'b1);
    tests_run++;
    if (fb.out_valid !== 1'b1 || fb.out_pc !== 32'h40 || fb.out_instr !== 32'h1010) begin
      tests_failed++;
      $display("FAIL redir_full_head: got v%0b pc %h instr %h want v1 pc 40 instr 1010",
               fb.out_valid, fb.out_pc, fb.out_instr);
    end
  endtask

  task automatic test_redirect_pop();
    cycle(1'b1, 32'h83, 1'b1);
    tests_run++;
    if (fb.out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL redir_pop_flush: got v%0b want v0", fb.out_valid);
    end
    cycle(1'b0, '0, 1'b1);
    tests_run++;
    if (fb.out_valid !== 1'b1 || fb.out_pc !== 32'h80 || fb.out_instr !== 32'h1020) begin
      tests_failed++;
      $display("FAIL redir_pop_head: got v%0b pc %h instr %h want v1 pc 80 instr 1020",
               fb.out_valid, fb.out_pc, fb.out_instr);
    end
    cycle(1'b0, '0, 1'b1);
    tests_run++;
    if (fb.out_pc !== 32'h84) begin
      tests_failed++; $display("FAIL redir_pop_next: got pc %h want 84", fb.out_pc);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc;
    cycle(1'b1, 32'hFFFF_FFFC, 1'b0);
    tests_run++;
    if (fb.icache_addr !== 8'hFF) begin
      tests_failed++; $display("FAIL wrap_addr: got %h want ff", fb.icache_addr);
    end
    for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b0);
    exp_pc = 32'hFFFF_FFFC;
    for (int k = 0; k < 5; k++) begin
      tests_run++;
      if (fb.count !== 3'd4 || fb.out_pc !== exp_pc
          || fb.out_instr !== (32'h1000 + 32'(exp_pc[9:2]))
          || fb.icache_addr !== 8'(((exp_pc + 32'd16) >> 2) & 32'hFF)) begin
        tests_failed++;
        $display("FAIL wrap_%0d: got cnt %0d pc %h instr %h addr %h want cnt 4 pc %h", k,
                 fb.count, fb.out_pc, fb.out_instr, fb.icache_addr, exp_pc);
      end
      cycle(1'b0, '0, 1'b1);
      exp_pc = exp_pc + 32'd4;
    end
  endtask

  task automatic test_random();
    logic        rv, rdy;
    logic [31:0] rpc;
    int          errs;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    cycle(1'b1, $urandom, 1'b0);
    errs = 0;
    for (int n = 0; n < 400; n++) begin
      rv  = ($urandom_range(0, 11) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      rpc = $urandom;
      cycle(rv, rpc, rdy);
      tests_run++;
      if (fb.out_valid !== (mq.size() != 0) || fb.count !== 3'(mq.size())
          || fb.icache_addr !== mpc[9:2]
          || (mq.size() != 0 && {fb.out_pc, fb.out_instr} !== mq[0])) begin
        tests_failed++;
        errs++;
        if (errs < 10)
          $display("FAIL random_%0d: got v%0b cnt %0d addr %h pc %h want cnt %0d addr %h head %h",
                   n, fb.out_valid, fb.count, fb.icache_addr, fb.out_pc, mq.size(), mpc[9:2],
                   (mq.size() != 0) ? mq[0] : 64'h0);
      end
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 4; i++) mem[i] = 32'h1000 + 32'(i);
    cycle(1'b1, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (fb.out_valid !== 1'b0 || fb.count !== 3'd0 || fb.out_pc !== 32'h0) begin
      tests_failed++;
      $display("FAIL async_reset: got v%0b cnt %0d pc %h want v0 cnt 0 pc 0",
               fb.out_valid, fb.count, fb.out_pc);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    cycle(1'b0, '0, 1'b1);
    tests_run++;
    if (fb.out_valid !== 1'b1 || fb.out_pc !== 32'h0 || fb.out_instr !== 32'h1000) begin
      tests_failed++;
      $display("FAIL async_restart: got v%0b pc %h instr %h want v1 pc 0 instr 1000",
               fb.out_valid, fb.out_pc, fb.out_instr);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000 + 32'(i);
    test_reset();
    test_stream();
    test_stall();
    test_redirect_full();
    test_redirect_pop();
    test_wrap();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
